// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch (if_*) and the LSU (ls_*)
// Ports: clk/reset; if_req/if_addr -> if_gnt/if_rvalid/if_rdata;
//        ls_req/ls_we/ls_addr/ls_wdata/ls_be -> ls_gnt/ls_rvalid/ls_rdata;
//        mem_en/mem_we/mem_addr/mem_wdata/mem_be -> memory, mem_rdata <- memory; busy = read in flight.
// Optional ARB_STATS_EN adds if_grant_cnt, ls_grant_cnt and stall_cnt outputs.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int READ_LATENCY   = 1,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]         if_grant_cnt,
  output logic [31:0]         ls_grant_cnt,
  output logic [31:0]         stall_cnt
`endif
);
  typedef enum logic {IDLE, WAIT} state_e;
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] streak_q, streak_d;
  logic src_q, src_d;
  logic resp, arb, ls_win, if_win, rd_gnt;
  always_comb begin
    resp     = state_q == WAIT && cnt_q == 3'd0;
    arb      = !reset && (state_q == IDLE || resp);
    // fetch overrides LSU only once the LSU has used up its streak allowance
    ls_win   = arb && ls_req && !(if_req && streak_q == 4'(MAX_LSU_STREAK));
    if_win   = arb && if_req && !ls_win;
    rd_gnt   = if_win || (ls_win && !ls_we);
    state_d  = (rd_gnt || (state_q == WAIT && cnt_q != 3'd0)) ? WAIT : IDLE;
    cnt_d    = rd_gnt ? 3'(READ_LATENCY - 1) : (cnt_q != 3'd0 ? cnt_q - 3'd1 : 3'd0);
    src_d    = rd_gnt ? ls_win : src_q;
    streak_d = (!if_req || if_win) ? 4'd0 :
               (ls_win && streak_q != 4'(MAX_LSU_STREAK)) ? streak_q + 4'd1 : streak_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      streak_q <= 4'd0;
      src_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      src_q    <= src_d;
    end
  end
  assign if_gnt    = if_win;
  assign ls_gnt    = ls_win;
  assign mem_en    = if_win || ls_win;
  assign mem_we    = ls_win && ls_we;
  assign mem_addr  = ls_win ? ls_addr : if_win ? if_addr : '0;
  assign mem_wdata = ls_win ? ls_wdata : '0;
  assign mem_be    = ls_win ? ls_be : if_win ? '1 : '0;
  assign if_rvalid = !reset && resp && !src_q;
  assign ls_rvalid = !reset && resp && src_q;
  assign if_rdata  = reset ? '0 : mem_rdata;
  assign ls_rdata  = reset ? '0 : mem_rdata;
  assign busy      = !reset && state_q == WAIT;
`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      if_grant_cnt <= '0;
      ls_grant_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if_grant_cnt <= if_grant_cnt + 32'(if_win);
      ls_grant_cnt <= ls_grant_cnt + 32'(ls_win);
      stall_cnt    <= stall_cnt + 32'(if_req && !if_win);
    end
  end
`endif
endmodule
